qs_fifo_packer: RTL and testbench
=================================

Name: qs_fifo_packer

Overview:
Downstream drain stage for qs_fifo. It pops DATA_W-bit entries from the FIFO's read side and packs PACK consecutive entries into one wide word. The word is presented on a valid/ready output port. A flush input forces out a partially filled word so that a stream tail is never stranded. Typical use is bridging the byte FIFO to a 32-bit sink.

Parameters:
DATA_W, 8, width of one FIFO entry (lane width)
PACK, 4, entries per output word; legal values >= 2
CNT_W, $clog2(PACK+1), width of the lane counter and out_bytes_o (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
fifo_empty_i  input  1  empty_o of upstream qs_fifo
fifo_pop_data_i  input  DATA_W  pop_data_o of qs_fifo; first-word-fall-through, valid whenever fifo_empty_i=0
fifo_pop_o  output  1  pop_i to qs_fifo; entry consumed on the clock edge where this is high
flush_i  input  1  single-cycle request to emit the partial word
out_valid_o  output  1  packed word available
out_ready_i  input  1  sink accepts the word on a clock edge where valid&ready
out_data_o  output  DATA_W*PACK  packed word; first-popped entry in lane 0 (LSBs)
out_bytes_o  output  CNT_W  number of valid lanes in out_data_o (1..PACK while valid)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid_o=0, out_data_o=0, out_bytes_o=0.
  - Internal accumulator cleared; lane counter cnt=0; state FILL.
  - fifo_pop_o is forced to 0 while reset is high.
- States: FILL (accumulating, out_valid_o=0) and HOLD (word presented, out_valid_o=1).
- Pop rule (combinational): fifo_pop_o = !reset && !fifo_empty_i && (state==FILL || out_ready_i). The block never pops while empty, so the FIFO's underflow guard is never exercised. It also never pops in HOLD unless the word leaves in the same cycle.
- FILL, pop cycle:
  - fifo_pop_data_i is written into lane cnt; cnt increments.
  - If cnt+1==PACK: the next cycle is HOLD with out_bytes_o=PACK, and cnt returns to 0.
- FILL, flush_i=1:
  - Let n = cnt + (pop this cycle ? 1 : 0). A same-cycle pop is included first.
  - If n>0: go to HOLD with out_bytes_o=n. Unused lanes (n..PACK-1) are driven 0.
  - If n==0: flush is ignored (no zero-length word is ever emitted).
- HOLD:
  - out_data_o and out_bytes_o stay stable until valid&ready.
  - flush_i is ignored in HOLD.
  - On acceptance: the accumulator clears. If a pop happens in the same cycle, that entry lands in lane 0 of the new word and cnt=1.
  - After acceptance, return to FILL; or stay in HOLD if PACK==1-equivalent completion occurs (not reachable since PACK>=2).
- Throughput: back-to-back words sustained at one entry per cycle. Output latency is 1 cycle from the completing pop edge to out_valid_o=1.
- Output is registered. out_valid_o never drops without acceptance (except on reset).
- Reset mid-word or in HOLD: partial data is discarded; no word is emitted after reset.
- Counter arithmetic is CNT_W wide; cnt never exceeds PACK-1 in FILL.

Decomposition:
- Package qs_fifo_packer_pkg holds:
  - typedef enum logic {FILL, HOLD} pack_state_t;
  - a localparam function for CNT_W.
- No sub-module. The lane write is a generate loop of per-lane enables decoded from cnt, inline.
- The bench instantiates qs_fifo (DEPTH>=4) upstream of this block.

Test Plan:
1. Push AB,CC,12,34 into the FIFO with out_ready_i=1 -> one word out_data_o=0x3412CCAB, out_bytes_o=4, exactly 4 pops, FIFO empty afterward.
2. Push AB,CC, wait until FIFO empty, pulse flush_i -> next cycle out_data_o=0x0000CCAB, out_bytes_o=2. A second flush pulse while idle produces nothing.
3. Hold out_ready_i=0 and push 8 entries 01..08 -> HOLD with 0x04030201 stable; fifo_pop_o stays 0 and full_o rises. Then raise ready -> 0x04030201 accepted, followed by 0x08070605.
4. Pulse flush_i in the same cycle as the 3rd pop of 11,22,33 -> out_data_o=0x00332211, out_bytes_o=3.
5. Stream 8 entries continuously with ready=1 -> two words on consecutive HOLD windows. The acceptance cycle and the first pop of the next word coincide with no bubble; total 8 pops in 8 cycles.
6. Assert reset after 2 of 4 entries are popped, then release -> out_valid_o=0 immediately. The next 4 pushed entries DD,EE,FF,00 yield 0x00FFEEDD, with no stale lanes.

Source files
------------

// File: rtl/qs_fifo_packer_pkg.sv
// qs_fifo_packer_pkg: shared types and helpers for the qs_fifo packer.
//   pack_state_t - FILL (accumulating lanes) / HOLD (word presented)
//   calc_cnt_w   - width of a counter that must hold 0..PACK inclusive
package qs_fifo_packer_pkg;

   typedef enum logic {FILL, HOLD} pack_state_t;

   function automatic int calc_cnt_w(input int pack);
      return $clog2(pack + 1);
   endfunction

endpackage

// File: rtl/qs_fifo_packer_if.sv
// qs_fifo_packer_if: FIFO read side + packed-word output handshake.
//   fifo_empty_i / fifo_pop_data_i / fifo_pop_o : first-word-fall-through pop port
//   flush_i                                     : request to emit a partial word
//   out_valid_o / out_ready_i / out_data_o / out_bytes_o : packed-word stream
// Modport master is the packer side, slave is the environment (FIFO + sink).
interface qs_fifo_packer_if
   import qs_fifo_packer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PACK   = 4
);
   localparam int CNT_W = calc_cnt_w(PACK);

   logic                     fifo_empty_i;
   logic [DATA_W-1:0]        fifo_pop_data_i;
   logic                     fifo_pop_o;
   logic                     flush_i;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [DATA_W*PACK-1:0]   out_data_o;
   logic [CNT_W-1:0]         out_bytes_o;

   modport master (
      input  fifo_empty_i, fifo_pop_data_i, flush_i, out_ready_i,
      output fifo_pop_o, out_valid_o, out_data_o, out_bytes_o
   );

   modport slave (
      output fifo_empty_i, fifo_pop_data_i, flush_i, out_ready_i,
      input  fifo_pop_o, out_valid_o, out_data_o, out_bytes_o
   );

endinterface

// File: rtl/qs_fifo_packer.sv
// qs_fifo_packer: drains DATA_W-bit entries from a FWFT FIFO and packs PACK
// consecutive entries into one word (first pop in lane 0 / LSBs).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - qs_fifo_packer_if.master (FIFO pop port, flush, packed output)
// A flush forces out a partially filled word; unused upper lanes read 0.
module qs_fifo_packer
   import qs_fifo_packer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PACK   = 4
)(
   input  logic              clk,
   input  logic              reset,
   qs_fifo_packer_if.master  bus
);

   localparam int CNT_W = calc_cnt_w(PACK);

   pack_state_t                  state, state_nxt;
   logic [CNT_W-1:0]             cnt, cnt_nxt, n_fill, out_bytes;
   logic [PACK-1:0][DATA_W-1:0]  acc, acc_wr, acc_nxt, out_data;
   logic [PACK-1:0]              lane_we;
   logic                         pop, load_out;

   // Never pop while empty; in HOLD only pop when the word leaves this cycle.
   assign pop = !reset && !bus.fifo_empty_i && (state == FILL || bus.out_ready_i);

   // Entries landing in count after this cycle's pop (also the new cnt in HOLD,
   // where cnt is 0).
   assign n_fill = cnt + CNT_W'(pop);

   // Per-lane write enables. In HOLD the only possible write is the first
   // entry of the next word, which goes to lane 0.
   for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      if (gi == 0) begin : g_l0
         assign lane_we[gi] = pop && (state == HOLD || cnt == '0);
      end else begin : g_ln
         assign lane_we[gi] = pop && state == FILL && cnt == CNT_W'(gi);
      end
   end

   always_comb begin
      acc_wr = acc;
      for (int i = 0; i < PACK; i++) begin
         if (lane_we[i]) acc_wr[i] = bus.fifo_pop_data_i;
      end
   end

   // The accumulator is cleared whenever a word is handed off, so lanes at or
   // above cnt are always zero; a flushed word therefore has zero upper lanes
   // without any masking.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = n_fill;
      acc_nxt   = acc_wr;
      load_out  = 1'b0;
      if (state == FILL) begin
         if (n_fill == CNT_W'(PACK) || (bus.flush_i && n_fill != '0)) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            load_out  = 1'b1;
         end
      end else begin
         if (bus.out_ready_i) state_nxt = FILL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FILL;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_bytes <= '0;
      end else begin
         cnt <= cnt_nxt;
         acc <= acc_nxt;
         if (load_out) begin
            out_data  <= acc_wr;
            out_bytes <= n_fill;
         end
      end
   end

   assign bus.fifo_pop_o  = pop;
   assign bus.out_valid_o = (state == HOLD);
   assign bus.out_data_o  = out_data;
   assign bus.out_bytes_o = out_bytes;

endmodule

// File: tb/tb_qs_fifo_packer.sv
module tb_qs_fifo_packer;

   localparam int DEPTH = 4;
   localparam int PACK  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   qs_fifo_packer_if #(.DATA_W(8), .PACK(PACK)) bus ();

   qs_fifo_packer #(.DATA_W(8), .PACK(PACK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // stimulus
   logic       ready    = 1'b0;
   logic       flush    = 1'b0;
   logic       push_req = 1'b0;
   logic [7:0] push_data = '0;

   // upstream FWFT FIFO model
   logic [7:0] fq[$];
   logic       f_empty = 1'b1;
   logic [7:0] f_head  = '0;

   assign bus.fifo_empty_i    = f_empty;
   assign bus.fifo_pop_data_i = f_head;
   assign bus.out_ready_i     = ready;
   assign bus.flush_i         = flush;

   // reference model: entries of the word being built, and the word presented
   logic [7:0]  pend[$];
   logic [31:0] exp_data[$];
   int          exp_bytes[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int pop_cnt = 0;
   int pop_cyc[$];

   logic       s_pop, s_ready, s_flush, s_empty;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_word();
      logic [31:0] w = '0;
      for (int i = 0; i < pend.size(); i++) w |= 32'(pend[i]) << (8 * i);
      return w;
   endfunction

   // mid-cycle: sample and compare against the model
   always @(negedge clk) begin
      s_pop   <= bus.fifo_pop_o;
      s_ready <= ready;
      s_flush <= flush;
      s_empty <= f_empty;
      if (!reset) begin
         chk("valid", bus.out_valid_o, exp_data.size() != 0);
         if (bus.out_valid_o && exp_data.size() != 0) begin
            chk("data", bus.out_data_o, exp_data[0]);
            chk("bytes", bus.out_bytes_o, exp_bytes[0]);
         end
         chk("pop", bus.fifo_pop_o, !f_empty && (exp_data.size() == 0 || ready));
      end
   end

   // clock edge: advance model and FIFO
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         pend.delete();
         exp_data.delete();
         exp_bytes.delete();
         fq.delete();
         f_empty <= 1'b1;
         f_head  <= '0;
      end else begin
         if (s_pop && !s_empty) begin
            pend.push_back(fq[0]);
            pop_cnt <= pop_cnt + 1;
            pop_cyc.push_back(cyc);
         end
         if (exp_data.size() != 0) begin
            if (s_ready) begin
               exp_data.pop_front();
               exp_bytes.pop_front();
            end
         end else if (pend.size() == PACK || (s_flush && pend.size() != 0)) begin
            exp_data.push_back(pack_word());
            exp_bytes.push_back(pend.size());
            pend.delete();
         end
         if (push_req && fq.size() < DEPTH) fq.push_back(push_data);
         if (s_pop && !s_empty) fq.pop_front();
         f_empty <= (fq.size() == 0);
         f_head  <= (fq.size() != 0) ? fq[0] : 8'h00;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      while (fq.size() >= DEPTH && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) chk("push_timeout", 1, 0);
      push_req  = 1'b1;
      push_data = d;
      step();
      push_req  = 1'b0;
   endtask

   task automatic wait_word(input string tag, input logic [31:0] d, input int b);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.out_valid_o && t < 100);
      chk({tag, "_valid"}, bus.out_valid_o, 1);
      chk({tag, "_data"}, bus.out_data_o, d);
      chk({tag, "_bytes"}, bus.out_bytes_o, b);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, t, vcnt;

      repeat (3) step();
      chk("rst_valid", bus.out_valid_o, 0);
      chk("rst_data", bus.out_data_o, 0);
      chk("rst_bytes", bus.out_bytes_o, 0);
      chk("rst_pop", bus.fifo_pop_o, 0);
      reset = 1'b0;
      step();

      // 1: full word
      ready = 1'b1;
      base  = pop_cnt;
      push(8'hAB); push(8'hCC); push(8'h12); push(8'h34);
      wait_word("t1", 32'h3412CCAB, 4);
      chk("t1_pops", pop_cnt - base, 4);
      chk("t1_empty", f_empty, 1);
      step(); step();

      // 2: flush of a partial word, then a flush with nothing buffered
      push(8'hAB); push(8'hCC);
      t = 0;
      while (fq.size() != 0 && t < 50) begin step(); t++; end
      flush = 1'b1; step(); flush = 1'b0;
      wait_word("t2", 32'h0000CCAB, 2);
      step(); step();
      flush = 1'b1; step(); flush = 1'b0;
      vcnt = 0;
      repeat (5) begin @(negedge clk); if (bus.out_valid_o) vcnt++; end
      chk("t2_idle_flush", vcnt, 0);
      step();

      // 3: sink stalled
      ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (3) begin
         @(negedge clk);
         chk("t3_pop_stall", bus.fifo_pop_o, 0);
         chk("t3_hold_data", bus.out_data_o, 32'h04030201);
      end
      chk("t3_full", fq.size(), DEPTH);
      step();
      ready = 1'b1;
      wait_word("t3a", 32'h04030201, 4);
      wait_word("t3b", 32'h08070605, 4);
      step(); step();

      // 4: flush coincident with the 3rd pop
      push(8'h11); push(8'h22); push(8'h33);
      flush = 1'b1;
      #1 chk("t4_pop_with_flush", bus.fifo_pop_o, 1);
      step();
      flush = 1'b0;
      wait_word("t4", 32'h00332211, 3);
      step(); step();

      // 5: continuous stream, no bubble at the word boundary
      pop_cyc.delete();
      fork
         begin
            for (int i = 0; i < 8; i++) push(8'h51 + 8'(i));
         end
         begin
            wait_word("t5a", 32'h54535251, 4);
            wait_word("t5b", 32'h58575655, 4);
         end
      join
      chk("t5_pops", pop_cyc.size(), 8);
      if (pop_cyc.size() == 8) chk("t5_span", pop_cyc[7] - pop_cyc[0], 7);
      step(); step();

      // 6: reset mid-word
      base = pop_cnt;
      push(8'hA1); push(8'hA2);
      t = 0;
      while (pop_cnt - base < 2 && t < 50) begin step(); t++; end
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", bus.out_valid_o, 0);
      chk("t6_rst_pop", bus.fifo_pop_o, 0);
      chk("t6_rst_data", bus.out_data_o, 0);
      chk("t6_rst_bytes", bus.out_bytes_o, 0);
      step();
      reset = 1'b0;
      step();
      push(8'hDD); push(8'hEE); push(8'hFF); push(8'h00);
      wait_word("t6", 32'h00FFEEDD, 4);
      step();

      // random traffic against the model
      repeat (1500) begin
         ready     = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         push_req  = (fq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
         push_data = 8'($urandom);
         step();
      end
      push_req = 1'b0;
      flush    = 1'b0;
      ready    = 1'b1;
      repeat (20) step();
      flush = 1'b1; step(); flush = 1'b0;
      repeat (10) step();
      chk("drain_valid", bus.out_valid_o, 0);
      chk("drain_empty", f_empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
